// File: rtl/multi_ch_trig_logger_if.sv
// Probe/firmware-side bus of the triggered multi-channel logger.
// Master drives the capture controls and read requests; slave is the logger itself.
interface multi_ch_trig_logger_if #(
  parameter int NUM_CH    = 4,
  parameter int NBT_DATA  = 12,
  parameter int AW        = 15,
  parameter int NBT_GPIOS = 32,
  parameter int NBT_DECIM = 8,
  parameter int CW        = 2
);
  logic [NUM_CH*NBT_DATA-1:0] i_data;
  logic                       i_valid;
  logic [CW-1:0]              i_ch_sel;
  logic [NBT_DECIM-1:0]       i_decim;
  logic [AW-1:0]              i_post_len;
  logic                       i_arm;
  logic                       i_trig;
  logic                       i_rd_en;
  logic [AW-1:0]              i_rd_idx;
  logic [NBT_GPIOS-1:0]       o_rd_data;
  logic                       o_rd_valid;
  logic [1:0]                 o_state;
  logic                       o_done;
  logic                       o_full;
  logic [AW-1:0]              o_trig_idx;

  modport master (
    output i_data, i_valid, i_ch_sel, i_decim, i_post_len, i_arm, i_trig, i_rd_en, i_rd_idx,
    input  o_rd_data, o_rd_valid, o_state, o_done, o_full, o_trig_idx
  );

  modport slave (
    input  i_data, i_valid, i_ch_sel, i_decim, i_post_len, i_arm, i_trig, i_rd_en, i_rd_idx,
    output o_rd_data, o_rd_valid, o_state, o_done, o_full, o_trig_idx
  );
endinterface

// File: rtl/multi_ch_trig_logger.sv
// Triggered circular-buffer logger: one selected channel, decimated, with a pre/post
// trigger split; samples are read back oldest-first through a single registered read port.
module multi_ch_trig_logger #(
  parameter int NUM_CH    = 4,
  parameter int NBT_DATA  = 12,
  parameter int RAM_DEPTH = 32768,
  parameter int NBT_GPIOS = 32,
  parameter int NBT_DECIM = 8
) (
  input  logic                  clk,
  input  logic                  i_reset,
  multi_ch_trig_logger_if.slave bus
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_POST = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        ch_sel_q, ch_sel_d;
  logic [NBT_DECIM-1:0] decim_q, decim_d, decim_cnt_q, decim_cnt_d;
  logic [AW-1:0]        post_len_q, post_len_d, post_cnt_q, post_cnt_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, trig_phys_q, trig_phys_d, trig_idx_q, trig_idx_d;
  logic                 full_q, full_d, rd_vld_q, rd_vld_d;

  logic                       capturing, wr, rd_acc;
  logic [AW-1:0]              oldest, rd_addr;
  logic signed [NBT_DATA-1:0] sel_sample;
  logic signed [NBT_DATA-1:0] ram [RAM_DEPTH];
  logic signed [NBT_DATA-1:0] rd_sample_q;

  function automatic logic [NBT_GPIOS-1:0] sign_ext(input logic signed [NBT_DATA-1:0] s);
    return NBT_GPIOS'(s);
  endfunction

  assign capturing = (state_q == ST_PRE) || (state_q == ST_POST);
  assign wr        = capturing && bus.i_valid && (decim_cnt_q == decim_q);
  assign rd_acc    = !capturing && bus.i_rd_en;
  assign oldest    = full_q ? wr_ptr_q : '0;
  assign rd_addr   = oldest + bus.i_rd_idx;

  always_comb begin
    sel_sample = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel_q == CW'(c)) sel_sample = bus.i_data[c*NBT_DATA +: NBT_DATA];
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_sel_d    = ch_sel_q;
    decim_d     = decim_q;
    post_len_d  = post_len_q;
    decim_cnt_d = decim_cnt_q;
    post_cnt_d  = post_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    full_d      = full_q;
    trig_phys_d = trig_phys_q;
    trig_idx_d  = trig_idx_q;
    rd_vld_d    = rd_acc;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_arm) begin
          state_d     = ST_PRE;
          ch_sel_d    = bus.i_ch_sel;
          decim_d     = bus.i_decim;
          post_len_d  = bus.i_post_len;
          decim_cnt_d = '0;
          post_cnt_d  = '0;
          wr_ptr_d    = '0;
          full_d      = 1'b0;
          trig_idx_d  = '0;
        end
      end
      default: begin
        if (bus.i_valid) decim_cnt_d = wr ? '0 : decim_cnt_q + 1'b1;
        if (wr) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (&wr_ptr_q) full_d = 1'b1;
          // The trigger only counts on a logged sample, which becomes the last pre-trigger entry.
          if (state_q == ST_PRE) begin
            if (bus.i_trig) begin
              trig_phys_d = wr_ptr_q;
              post_cnt_d  = '0;
              state_d     = (post_len_q == '0) ? ST_DONE : ST_POST;
            end
          end else begin
            post_cnt_d = post_cnt_q + 1'b1;
            if (post_cnt_q == post_len_q - 1'b1) state_d = ST_DONE;
          end
        end
      end
    endcase
    if (state_d == ST_DONE && state_q != ST_DONE)
      trig_idx_d = trig_phys_d - (full_d ? wr_ptr_d : '0);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      ch_sel_q    <= '0;
      decim_q     <= '0;
      post_len_q  <= '0;
      decim_cnt_q <= '0;
      post_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      full_q      <= 1'b0;
      trig_phys_q <= '0;
      trig_idx_q  <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_sel_q    <= ch_sel_d;
      decim_q     <= decim_d;
      post_len_q  <= post_len_d;
      decim_cnt_q <= decim_cnt_d;
      post_cnt_q  <= post_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      full_q      <= full_d;
      trig_phys_q <= trig_phys_d;
      trig_idx_q  <= trig_idx_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr) ram[wr_ptr_q] <= sel_sample;
    if (rd_acc) rd_sample_q <= ram[rd_addr];
  end

  assign bus.o_rd_data  = rd_vld_q ? sign_ext(rd_sample_q) : '0;
  assign bus.o_rd_valid = rd_vld_q;
  assign bus.o_state    = state_q;
  assign bus.o_done     = (state_q == ST_DONE);
  assign bus.o_full     = full_q;
  assign bus.o_trig_idx = trig_idx_q;
endmodule
